// File: rtl/iqdemap_qpsk.sv
// QPSK hard-decision demapper: sign-slices each I/Q symbol, then packs the
// decisions LSB-first into 128-bit words with an optional early flush.
module iqdemap_qpsk (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ce,
   input  logic         valid_i,
   input  logic [10:0]  ar,
   input  logic [10:0]  ai,
   input  logic         flush,
   output logic         valid_o,
   output logic [127:0] writer_data,
   output logic [7:0]   nbits,
   output logic         valid_raw,
   output logic [1:0]   raw
);

   logic         flush_q;
   logic [127:0] acc;
   logic [127:0] acc_next;
   logic [6:0]   cnt;
   logic [6:0]   held;
   logic         emit;

   // Symbols held after the current stage-1 pair is merged; never exceeds 64.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      acc_next = acc;
      held     = cnt;
      if (valid_raw) begin
         acc_next = acc | ({126'd0, raw} << {cnt, 1'b0});
         held     = cnt + 7'd1;
      end
      emit = (valid_raw && (cnt == 7'd63)) || (flush_q && ((cnt != 7'd0) || valid_raw));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_raw   <= 1'b0;
         raw         <= 2'b00;
         flush_q     <= 1'b0;
         valid_o     <= 1'b0;
         writer_data <= '0;
         nbits       <= '0;
         acc         <= '0;
         cnt         <= '0;
      end else if (ce) begin
         // NOTE: registered state uses non-blocking assignment so every flop sees pre-edge values.
         valid_raw <= valid_i;
         flush_q   <= flush;
         if (valid_i) raw <= {ai[10], ar[10]};

         valid_o <= emit;
         if (emit) begin
            writer_data <= acc_next;
            nbits       <= {held, 1'b0};
            acc         <= '0;
            cnt         <= '0;
         end else begin
            acc <= acc_next;
            cnt <= held;
         end
      end
   end

endmodule
